// File: rtl/awe_pkg.sv
// Shared encodings for the AWE weight streamer: FSM states, FIFO depth and
// the occupancy projection used by the read-issue throttle.
package awe_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } awe_state_e;

   // Buffer occupancy one cycle ahead, counting the read already in flight.
   function automatic logic [2:0] occ_after(input logic [1:0] occ,
                                             input logic       inflight,
                                             input logic       pop);
      return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/awe_stream_fifo.sv
// Two-entry register FIFO that absorbs the table read latency; the head entry
// drives the outgoing stream word directly from registers.
module awe_stream_fifo
   import awe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       occ,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       occ_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign head_data = mem_r[rd_ptr_r];
   assign occ       = occ_r;
   assign full      = (occ_r == 2'd2);
   assign empty     = (occ_r == 2'd0);
   assign do_push_s = push & (~full | pop);
   assign do_pop_s  = pop & ~empty;

   // Storage, pointers and occupancy update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         occ_r    <= 2'd0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end

endmodule

// File: rtl/awe_weight_streamer.sv
// Read-side sequencer for the AWE weight table: issues consecutive addresses,
// absorbs the one-cycle table latency and streams the weights out.
module awe_weight_streamer
   import awe_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int N_DEPTH = 256,
   parameter int W_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [W_DEPTH-1:0] base_addr,
   input  logic [W_DEPTH:0]   count,
   output logic               busy,
   output logic               done,
   output logic [W_DEPTH-1:0] rd_addr,
   input  logic [WIDTH-1:0]   rd_data,
   output logic               m_valid,
   output logic [WIDTH-1:0]   m_data,
   output logic               m_last,
   input  logic               m_ready
);

   localparam logic [W_DEPTH:0]   CNT_ZERO = {(W_DEPTH+1){1'b0}};
   localparam logic [W_DEPTH:0]   CNT_ONE  = {{W_DEPTH{1'b0}}, 1'b1};
   localparam logic [W_DEPTH-1:0] PTR_ZERO = {W_DEPTH{1'b0}};
   localparam logic [W_DEPTH-1:0] PTR_ONE  = {{(W_DEPTH-1){1'b0}}, 1'b1};
   localparam logic [W_DEPTH-1:0] PTR_LAST = W_DEPTH'(N_DEPTH - 1);

   awe_state_e         state_r;
   awe_state_e         state_nxt_s;
   logic [W_DEPTH-1:0] ptr_r;
   logic [W_DEPTH:0]   issue_cnt_r;
   logic [W_DEPTH:0]   deliver_cnt_r;
   logic               inflight_r;
   logic               busy_r;
   logic               done_r;
   logic [1:0]         occ_s;
   logic               full_s;
   logic               empty_s;
   logic               pop_s;
   logic               issue_s;
   logic               launch_s;

   assign pop_s    = m_valid & m_ready;
   assign m_valid  = ~empty_s;
   assign m_last   = m_valid & (deliver_cnt_r == CNT_ONE);
   assign rd_addr  = ptr_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign launch_s = (state_r == S_IDLE) & start & (count != CNT_ZERO);

   // A read may only be launched if its word is guaranteed a FIFO slot.
   assign issue_s = (state_r == S_RUN) & (issue_cnt_r != CNT_ZERO) &
                    ~(full_s & ~pop_s) &
                    (occ_after(occ_s, inflight_r, pop_s) <= 3'd1);

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               if (count != CNT_ZERO) begin
                  state_nxt_s = S_RUN;
               end else begin
                  state_nxt_s = S_DONE;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (pop_s && (deliver_cnt_r == CNT_ONE)) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State, status outputs, pointer and issue/deliver counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= S_IDLE;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         ptr_r         <= PTR_ZERO;
         issue_cnt_r   <= CNT_ZERO;
         deliver_cnt_r <= CNT_ZERO;
         inflight_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         busy_r     <= (state_nxt_s == S_RUN);
         done_r     <= (state_nxt_s == S_DONE);
         inflight_r <= issue_s;
         if (launch_s) begin
            ptr_r         <= base_addr;
            issue_cnt_r   <= count;
            deliver_cnt_r <= count;
         end else begin
            if (issue_s) begin
               ptr_r       <= (ptr_r == PTR_LAST) ? PTR_ZERO : ptr_r + PTR_ONE;
               issue_cnt_r <= issue_cnt_r - CNT_ONE;
            end
            if (pop_s) begin
               deliver_cnt_r <= deliver_cnt_r - CNT_ONE;
            end
         end
      end
   end

   awe_stream_fifo #(
      .WIDTH(WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_r),
      .push_data (rd_data),
      .pop       (pop_s),
      .head_data (m_data),
      .occ       (occ_s),
      .full      (full_s),
      .empty     (empty_s)
   );

endmodule

// File: tb/tb_awe_weight_streamer.sv
// Bench for awe_weight_streamer: a table of runs plus random runs, each
// checked word-by-word against the table contents read in address order.
module tb_awe_weight_streamer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  count;
   logic        busy;
   logic        done;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_last;
   logic        m_ready;

   logic [31:0] tbl [256];

   int vectors;
   int miscompares;

   typedef struct {
      logic [7:0]  base;
      logic [8:0]  cnt;
      int          mode;     // 0: ready high, 1: 1,0,0,1 pattern, 2: random
      int          inject;   // 0: none, 1: start mid-run, 2: start in done cycle
      int          exp_lat;  // 0: do not check
      bit          chk_last;
      logic [31:0] exp_last;
   } vec_t;

   vec_t vecs [8];

   awe_weight_streamer #(
      .WIDTH   (32),
      .N_DEPTH (256),
      .W_DEPTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_ready   (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered read port of the weight table.
   always @(posedge clk) rd_data <= tbl[rd_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},    64'(busy),    64'd0);
      check({tag, "_done"},    64'(done),    64'd0);
      check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      check({tag, "_m_last"},  64'(m_last),  64'd0);
      check({tag, "_m_data"},  64'(m_data),  64'd0);
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
   endtask

   task automatic run(input vec_t v);
      logic [31:0] exp_q [$];
      logic [3:0]  pat;
      logic [31:0] prev_data;
      logic [31:0] last_word;
      logic        r;
      bit          seen_done;
      bit          prev_stall;
      int          idx;
      int          cyc;
      int          last_pop_cyc;
      int          first_valid_cyc;
      pat = 4'b1001;
      for (int i = 0; i < int'(v.cnt); i++) exp_q.push_back(tbl[(int'(v.base) + i) % 256]);
      @(negedge clk);
      start = 1'b1; base_addr = v.base; count = v.cnt; m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; idx = 0; last_pop_cyc = 0; first_valid_cyc = 0;
      seen_done = 1'b0; prev_stall = 1'b0; prev_data = 32'd0; last_word = 32'd0;
      while (!seen_done && cyc < 3000) begin
         if (v.inject == 1 && cyc == 4) begin
            start = 1'b1; base_addr = 8'd200; count = 9'd9;
         end else begin
            start = 1'b0;
         end
         case (v.mode)
            0:       r = 1'b1;
            1:       r = pat[cyc % 4];
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (done) begin
            check("done_cycle", 64'(cyc), 64'(last_pop_cyc + 1));
            check("words_delivered", 64'(idx), 64'(v.cnt));
            check("busy_at_done", 64'(busy), 64'd0);
            seen_done = 1'b1;
            m_ready = 1'b0;
            if (v.inject == 2) begin
               start = 1'b1; base_addr = 8'd3; count = 9'd5;
            end
         end else begin
            check("busy", 64'(busy), 64'(v.cnt != 9'd0));
            if (prev_stall) check("stall_valid", 64'(m_valid), 64'd1);
            m_ready = r;
            if (m_valid) begin
               if (first_valid_cyc == 0) first_valid_cyc = cyc;
               if (prev_stall) check("stall_data", 64'(m_data), 64'(prev_data));
               if (idx >= int'(v.cnt)) begin
                  check("extra_word", 64'(m_valid), 64'd0);
               end else begin
                  check("last", 64'(m_last), 64'(idx == int'(v.cnt) - 1));
                  if (r) begin
                     check("data", 64'(m_data), 64'(exp_q[idx]));
                     if (idx == int'(v.cnt) - 1) last_word = m_data;
                     idx++;
                     last_pop_cyc = cyc;
                     prev_stall = 1'b0;
                  end else begin
                     prev_stall = 1'b1;
                     prev_data = m_data;
                  end
               end
            end else begin
               prev_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!seen_done) check("timeout_done", 64'(seen_done), 64'd1);
      if (v.exp_lat != 0) check("latency", 64'(first_valid_cyc), 64'(v.exp_lat));
      if (v.chk_last) check("last_word", 64'(last_word), 64'(v.exp_last));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         check("idle_busy", 64'(busy), 64'd0);
         check("idle_valid", 64'(m_valid), 64'd0);
         check("idle_done", 64'(done), 64'd0);
      end
   endtask

   task automatic reset_mid_run();
      int  pops;
      int  stalls;
      bit  hit;
      @(negedge clk);
      start = 1'b1; base_addr = 8'd10; count = 9'd8; m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; pops = 0; stalls = 0; hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
         if (m_valid && pops < 2) begin
            check("pre_rst_data", 64'(m_data), 64'(tbl[10 + pops]));
            m_ready = 1'b1;
            pops++;
         end else begin
            m_ready = 1'b0;
            if (m_valid && pops == 2) stalls++;
            if (stalls == 2) hit = 1'b1;
         end
         if (!hit) @(negedge clk);
      end
      check("rst_reached_stall", 64'(hit), 64'd1);
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      check("midrst_held_done", 64'(done), 64'd0);
      rst = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; start = 1'b0; base_addr = 8'd0; count = 9'd0; m_ready = 1'b0;
      for (int i = 0; i < 256; i++) tbl[i] = 32'(i + 100);

      vecs[0] = '{8'd5,   9'd4,   0, 0, 3, 1'b1, 32'd108};
      vecs[1] = '{8'd254, 9'd4,   0, 0, 3, 1'b1, 32'd101};
      vecs[2] = '{8'd20,  9'd8,   1, 0, 0, 1'b1, 32'd127};
      vecs[3] = '{8'd40,  9'd8,   2, 0, 0, 1'b1, 32'd147};
      vecs[4] = '{8'd9,   9'd0,   0, 0, 0, 1'b0, 32'd0};
      vecs[5] = '{8'd7,   9'd256, 0, 0, 3, 1'b1, 32'd106};
      vecs[6] = '{8'd60,  9'd6,   0, 1, 3, 1'b1, 32'd165};
      vecs[7] = '{8'd30,  9'd2,   1, 2, 0, 1'b1, 32'd131};

      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      for (int n = 0; n < 8; n++) run(vecs[n]);

      reset_mid_run();
      check_reset_values("post_rst");
      run('{8'd50, 9'd3, 0, 0, 3, 1'b1, 32'd152});

      for (int i = 0; i < 256; i++) tbl[i] = $urandom;
      for (int n = 0; n < 8; n++) begin
         vec_t rv;
         rv.base     = 8'($urandom_range(0, 255));
         rv.cnt      = 9'($urandom_range(0, 40));
         rv.mode     = 2;
         rv.inject   = 0;
         rv.exp_lat  = 0;
         rv.chk_last = 1'b0;
         rv.exp_last = 32'd0;
         run(rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
